tuss_spi_responder: RTL and testbench

- SPI target (responder) that models the TUSS ultrasonic front-end register interface. It sits at the far end of the team's SPI configuration master and is used for closed-loop simulation and FPGA loop-back testing.
- Oversamples sclk/nss/mosi in the gclk domain and decodes 16-bit frames into a 12-entry register bank (addresses 0x10–0x1B).
- Returns status and read data on miso; exposes decoded configuration fields to downstream logic.

---
 rtl/tuss_spi_responder_if.sv | 24 ++
 rtl/tuss_spi_responder.sv | 207 ++++++++++++++++++++
 tb/tb_tuss_spi_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tuss_spi_responder_if.sv
// SPI bus between the configuration master and the TUSS register responder.
interface tuss_spi_responder_if;
  logic sclk;
  logic nss;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk,
    output nss,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sclk,
    input  nss,
    input  mosi,
    output miso,
    output miso_oe
  );
endinterface

// File: rtl/tuss_spi_responder.sv
// TUSS front-end register responder: oversamples the SPI bus in the gclk
// domain, decodes 16-bit frames {rw, addr[5:0], parity, data[7:0]} into a
// small register bank and returns {STAT, RDATA} on miso.
module tuss_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [5:0] BASE_ADDR   = 6'h10,
  parameter int         NUM_REGS    = 12
) (
  input  logic                 gclk,
  input  logic                 rstn,
  tuss_spi_responder_if.slave  spi,
  output logic                 reg_wr,
  output logic [5:0]           reg_wr_addr,
  output logic [7:0]           reg_wr_data,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 abort_err,
  output logic [4:0]           pulse_num,
  output logic [1:0]           io_mode,
  output logic [3:0]           vdrv_sel
);

  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SETTLE_MAX = SYNC_STAGES + 1;
  localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

  localparam logic [IDX_W-1:0] IDX_IO_MODE = IDX_W'(6'h14 - BASE_ADDR);
  localparam logic [IDX_W-1:0] IDX_VDRV    = IDX_W'(6'h16 - BASE_ADDR);
  localparam logic [IDX_W-1:0] IDX_PULSE   = IDX_W'(6'h1A - BASE_ADDR);

  // Address lies inside the implemented register window.
  function automatic logic in_range(input logic [5:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
           ({1'b0, addr} < ({1'b0, BASE_ADDR} + 7'(NUM_REGS)));
  endfunction

  // Frame parity is odd over all sixteen bits.
  function automatic logic parity_ok(input logic [15:0] word);
    return ^word;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] nss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_p1;
  logic                   nss_p1;
  logic                   sclk_p0;
  logic                   nss_p0;
  logic                   mosi_p0;

  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   nss_rise;
  logic                   nss_fall;

  logic [SETTLE_W-1:0]    settle;
  logic                   armed;
  logic                   active;
  logic [4:0]             bit_cnt;
  logic [3:0]             rise_cnt;
  logic [14:0]            shreg;
  logic [14:0]            tx_word;
  logic                   miso_q;
  logic                   prev_par;
  logic                   prev_addr;
  logic                   prev_abort;
  logic [7:0]             regs [NUM_REGS];

  logic [15:0]            shift_next;
  logic [5:0]             look_addr;
  logic [IDX_W-1:0]       look_idx;
  logic [7:0]             rdata_lookup;
  logic [5:0]             end_addr;
  logic [IDX_W-1:0]       end_idx;
  logic                   end_par_ok;
  logic                   end_addr_ok;
  logic [7:0]             stat_now;

  assign sclk_p0 = sclk_sync[SYNC_STAGES-1];
  assign nss_p0  = nss_sync[SYNC_STAGES-1];
  assign mosi_p0 = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_p0 & ~sclk_p1;
  assign sclk_fall = ~sclk_p0 & sclk_p1;
  assign nss_rise  = nss_p0 & ~nss_p1;
  assign nss_fall  = ~nss_p0 & nss_p1;

  assign shift_next   = {shreg, mosi_p0};
  assign look_addr    = {shreg[4:0], mosi_p0};
  assign look_idx     = IDX_W'(look_addr - BASE_ADDR);
  assign rdata_lookup = (shreg[5] && in_range(look_addr)) ? regs[look_idx] : 8'h00;
  assign end_addr     = shift_next[14:9];
  assign end_idx      = IDX_W'(end_addr - BASE_ADDR);
  assign end_par_ok   = parity_ok(shift_next);
  assign end_addr_ok  = in_range(end_addr);
  assign stat_now     = {prev_par, prev_addr, prev_abort, 5'b0};

  assign spi.miso    = miso_q & ~nss_p0;
  assign spi.miso_oe = ~nss_p0;

  assign pulse_num = regs[IDX_PULSE][4:0];
  assign io_mode   = regs[IDX_IO_MODE][1:0];
  assign vdrv_sel  = regs[IDX_VDRV][3:0];

  // Input synchronizers plus one delayed copy for edge detection (sync -> p0 -> p1).
  always_ff @(posedge gclk) begin
    if (!rstn) begin
      sclk_sync <= '0;
      nss_sync  <= '1;
      mosi_sync <= '0;
      sclk_p1   <= 1'b0;
      nss_p1    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi.nss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      sclk_p1   <= sclk_p0;
      nss_p1    <= nss_p0;
    end
  end

  // Arm only after the synchronizers have flushed their reset preset and nss
  // is genuinely high, so a select held low across reset is ignored.
  always_ff @(posedge gclk) begin
    if (!rstn) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      if (settle != SETTLE_W'(SETTLE_MAX))
        settle <= settle + 1'b1;
      if ((settle == SETTLE_W'(SETTLE_MAX)) && nss_p0 && nss_p1)
        armed <= 1'b1;
    end
  end

  // Frame engine: shift on sclk fall, drive miso on sclk rise, commit on bit 16.
  always_ff @(posedge gclk) begin
    if (!rstn) begin
      active      <= 1'b0;
      bit_cnt     <= '0;
      rise_cnt    <= '0;
      shreg       <= '0;
      tx_word     <= '0;
      miso_q      <= 1'b0;
      prev_par    <= 1'b0;
      prev_addr   <= 1'b0;
      prev_abort  <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      abort_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      reg_wr     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      abort_err  <= 1'b0;
      if (nss_fall) begin
        if (armed) begin
          active   <= 1'b1;
          bit_cnt  <= '0;
          rise_cnt <= '0;
          tx_word  <= {stat_now[6:0], 8'h00};
          miso_q   <= stat_now[7];
        end
      end else if (nss_rise) begin
        if (active && (bit_cnt != 5'd0) && (bit_cnt != 5'd16)) begin
          abort_err  <= 1'b1;
          prev_par   <= 1'b0;
          prev_addr  <= 1'b0;
          prev_abort <= 1'b1;
        end
        active   <= 1'b0;
        bit_cnt  <= '0;
        rise_cnt <= '0;
        miso_q   <= 1'b0;
      end else if (active && !nss_p0) begin
        if (sclk_fall && (bit_cnt != 5'd16)) begin
          shreg   <= shift_next[14:0];
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd6)
            tx_word[7:0] <= rdata_lookup;
          if (bit_cnt == 5'd15) begin
            frame_done <= 1'b1;
            frame_err  <= !(end_par_ok && end_addr_ok);
            prev_par   <= !end_par_ok;
            prev_addr  <= !end_addr_ok;
            prev_abort <= 1'b0;
            if (!shift_next[15] && end_par_ok && end_addr_ok) begin
              reg_wr         <= 1'b1;
              reg_wr_addr    <= end_addr;
              reg_wr_data    <= shift_next[7:0];
              regs[end_idx]  <= shift_next[7:0];
            end
          end
        end
        if (sclk_rise && (rise_cnt != 4'd15)) begin
          rise_cnt <= rise_cnt + 4'd1;
          miso_q   <= tx_word[4'd14 - rise_cnt];
        end
      end
    end
  end

endmodule

// File: tb/tb_tuss_spi_responder.sv
// Bench for tuss_spi_responder: directed frames from the bring-up list followed
// by randomized frames, all checked against a frame-level register model.
module tb_tuss_spi_responder;

  logic       gclk = 1'b0;
  logic       rstn = 1'b0;
  logic       reg_wr;
  logic [5:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       frame_done;
  logic       frame_err;
  logic       abort_err;
  logic [4:0] pulse_num;
  logic [1:0] io_mode;
  logic [3:0] vdrv_sel;

  tuss_spi_responder_if spi_bus ();

  tuss_spi_responder dut (
    .gclk        (gclk),
    .rstn        (rstn),
    .spi         (spi_bus),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .abort_err   (abort_err),
    .pulse_num   (pulse_num),
    .io_mode     (io_mode),
    .vdrv_sel    (vdrv_sel)
  );

  always #5 gclk = ~gclk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled on the inactive edge.
  int         n_wr = 0, n_done = 0, n_err = 0, n_abort = 0, n_orphan = 0;
  logic [5:0] last_addr = '0;
  logic [7:0] last_data = '0;
  always @(negedge gclk) begin
    if (reg_wr) begin
      n_wr++;
      last_addr = reg_wr_addr;
      last_data = reg_wr_data;
    end
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (frame_err && !frame_done) n_orphan++;
    if (abort_err) n_abort++;
  end

  // Reference model: register contents by absolute address plus status flags.
  logic [7:0] mreg [64];
  logic       m_par, m_addr, m_abort;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge gclk);
  endtask

  function automatic logic in_win(input logic [5:0] a);
    return (a >= 6'h10) && (a <= 6'h1B);
  endfunction

  function automatic logic [15:0] mk(input logic rw, input logic [5:0] a,
                                     input logic [7:0] d, input logic good);
    logic p;
    p = ~(^{rw, a, d});
    if (!good) p = ~p;
    return {rw, a, p, d};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
    m_par = 1'b0;
    m_addr = 1'b0;
    m_abort = 1'b0;
  endtask

  task automatic check_decoded(input string tag);
    check_val({tag, "_pulse_num"}, 32'(pulse_num), 32'(mreg[6'h1A][4:0]));
    check_val({tag, "_io_mode"}, 32'(io_mode), 32'(mreg[6'h14][1:0]));
    check_val({tag, "_vdrv_sel"}, 32'(vdrv_sel), 32'(mreg[6'h16][3:0]));
  endtask

  // One select period: nbits clocked bits of word, then extra dummy clocks.
  task automatic run_frame(input string tag, input logic [15:0] word, input int nbits,
                           input int extra, input int h, output logic [15:0] rx);
    int         w0, d0, e0, a0;
    logic [15:0] exp_rx;
    logic [7:0]  rdata;
    logic        par_ok, addr_ok, exp_wr;
    w0 = n_wr; d0 = n_done; e0 = n_err; a0 = n_abort;
    rdata  = (word[15] && in_win(word[14:9])) ? mreg[word[14:9]] : 8'h00;
    exp_rx = {m_par, m_addr, m_abort, 5'b0, rdata};
    rx = '0;
    spi_bus.nss = 1'b0;
    tick(h);
    check_val({tag, "_oe_low"}, 32'(spi_bus.miso_oe), 32'd1);
    rx[15] = spi_bus.miso;
    for (int i = 0; i < nbits; i++) begin
      spi_bus.mosi = word[15-i];
      spi_bus.sclk = 1'b1;
      tick(h);
      if (i < 15) rx[14-i] = spi_bus.miso;
      spi_bus.sclk = 1'b0;
      tick(h);
    end
    for (int i = 0; i < extra; i++) begin
      spi_bus.mosi = 1'($urandom);
      spi_bus.sclk = 1'b1;
      tick(h);
      spi_bus.sclk = 1'b0;
      tick(h);
    end
    tick(h);
    spi_bus.nss = 1'b1;
    tick(h + 4);
    check_val({tag, "_oe_high"}, 32'(spi_bus.miso_oe), 32'd0);
    check_val({tag, "_miso_idle"}, 32'(spi_bus.miso), 32'd0);
    par_ok  = ^word;
    addr_ok = in_win(word[14:9]);
    exp_wr  = (nbits == 16) && !word[15] && par_ok && addr_ok;
    if (nbits == 16) begin
      check_val({tag, "_miso"}, 32'(rx), 32'(exp_rx));
      check_val({tag, "_done"}, 32'(n_done - d0), 32'd1);
      check_val({tag, "_err"}, 32'(n_err - e0), 32'(!(par_ok && addr_ok)));
      check_val({tag, "_abort"}, 32'(n_abort - a0), 32'd0);
      m_par = !par_ok;
      m_addr = !addr_ok;
      m_abort = 1'b0;
    end else begin
      check_val({tag, "_done"}, 32'(n_done - d0), 32'd0);
      check_val({tag, "_abort"}, 32'(n_abort - a0), 32'(nbits != 0));
      if (nbits != 0) begin
        m_par = 1'b0;
        m_addr = 1'b0;
        m_abort = 1'b1;
      end
    end
    check_val({tag, "_wr"}, 32'(n_wr - w0), 32'(exp_wr));
    if (exp_wr) begin
      mreg[word[14:9]] = word[7:0];
      check_val({tag, "_wr_addr"}, 32'(last_addr), 32'(word[14:9]));
      check_val({tag, "_wr_data"}, 32'(last_data), 32'(word[7:0]));
    end
    check_decoded(tag);
  endtask

  logic [15:0] rx;
  int          w0, d0, a0;

  initial begin
    spi_bus.sclk = 1'b0;
    spi_bus.nss  = 1'b1;
    spi_bus.mosi = 1'b0;
    model_reset();
    rstn = 1'b0;
    tick(4);
    check_val("rst_reg_wr", 32'(reg_wr), 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_miso_oe", 32'(spi_bus.miso_oe), 32'd0);
    check_val("rst_miso", 32'(spi_bus.miso), 32'd0);
    check_decoded("rst");
    rstn = 1'b1;
    tick(8);

    // Directed bring-up frames.
    run_frame("wr1a", 16'h3504, 16, 0, 4, rx);
    check_val("wr1a_pulse_const", 32'(pulse_num), 32'd4);
    run_frame("rd1a", mk(1'b1, 6'h1A, 8'h00, 1'b1), 16, 0, 4, rx);
    check_val("rd1a_word_const", 32'(rx), 32'h0004);
    run_frame("badpar", 16'h2580, 16, 0, 4, rx);
    run_frame("rd12", mk(1'b1, 6'h12, 8'h00, 1'b1), 16, 0, 5, rx);
    check_val("rd12_word_const", 32'(rx), 32'h8000);
    run_frame("wr30", mk(1'b0, 6'h30, 8'h5A, 1'b1), 16, 0, 4, rx);
    run_frame("rd30", mk(1'b1, 6'h30, 8'h00, 1'b1), 16, 0, 4, rx);
    check_val("rd30_word_const", 32'(rx), 32'h4000);
    run_frame("abort14", mk(1'b0, 6'h14, 8'h03, 1'b1), 9, 0, 4, rx);
    check_val("abort14_io_const", 32'(io_mode), 32'd0);
    run_frame("wr14", mk(1'b0, 6'h14, 8'h02, 1'b1), 16, 0, 4, rx);
    check_val("wr14_stat_const", 32'(rx[15:8]), 32'h20);
    check_val("wr14_io_const", 32'(io_mode), 32'd2);
    run_frame("idle_sel", 16'h0000, 0, 0, 4, rx);
    run_frame("extra16", mk(1'b0, 6'h16, 8'h09, 1'b1), 16, 3, 4, rx);

    // Reset asserted in the middle of a frame; rest of that select is ignored.
    w0 = n_wr; d0 = n_done; a0 = n_abort;
    spi_bus.nss = 1'b0;
    tick(4);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        rstn = 1'b0;
        tick(2);
        model_reset();
        check_val("midrst_oe_in_reset", 32'(spi_bus.miso_oe), 32'd0);
        check_decoded("midrst_in_reset");
        rstn = 1'b1;
        tick(4);
        check_val("midrst_oe_follows", 32'(spi_bus.miso_oe), 32'd1);
      end
      spi_bus.mosi = 1'($urandom);
      spi_bus.sclk = 1'b1;
      tick(4);
      spi_bus.sclk = 1'b0;
      tick(4);
    end
    tick(4);
    spi_bus.nss = 1'b1;
    tick(8);
    check_val("midrst_wr", 32'(n_wr - w0), 32'd0);
    check_val("midrst_done", 32'(n_done - d0), 32'd0);
    check_val("midrst_abort", 32'(n_abort - a0), 32'd0);
    check_val("midrst_oe_high", 32'(spi_bus.miso_oe), 32'd0);
    check_decoded("midrst_after");
    run_frame("post_rst_rd", mk(1'b1, 6'h16, 8'h00, 1'b1), 16, 0, 4, rx);

    // Randomized frames against the model.
    for (int n = 0; n < 40; n++) begin
      logic [5:0]  a;
      logic [15:0] word;
      int          nb, ex, h;
      a    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(14, 29));
      word = mk(1'($urandom), a, 8'($urandom), $urandom_range(0, 4) != 0);
      nb   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : 16;
      ex   = (nb == 16) ? $urandom_range(0, 2) : 0;
      h    = $urandom_range(4, 6);
      run_frame("rnd", word, nb, ex, h, rx);
    end

    check_val("no_orphan_err", 32'(n_orphan), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
